// File: rtl/portal_output_arbiter.sv
// Portal output arbiter: per-channel holding registers feed a round-robin
// arbiter that pushes tagged words ({channel+1, payload}) into a small FIFO
// drained by the downstream pipe. Tag 0 is never produced.
module portal_output_arbiter #(
  parameter int NCH    = 4,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 8
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NCH-1:0]           meth__ENA,
  input  logic [NCH*DATA_W-1:0]    meth_v,
  output logic [NCH-1:0]           meth__RDY,
  output logic                     pipe_enq__ENA,
  output logic [TAG_W+DATA_W-1:0]  pipe_enq_v,
  input  logic                     pipe_enq__RDY,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(NCH);

  logic [NCH-1:0]              hold_valid;
  logic [DATA_W-1:0]           hold_data [NCH];

  logic [IDX_W-1:0]            rr_ptr;
  logic [IDX_W-1:0]            rr_next;
  logic [NCH-1:0]              grant;
  logic [IDX_W-1:0]            grant_idx;
  logic                        push;
  logic [TAG_W+DATA_W-1:0]     push_word;

  logic [TAG_W+DATA_W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic                        full;
  logic                        pop;
  logic [NCH-1:0]              accept;

  assign full          = (count == CNT_W'(DEPTH));
  assign pipe_enq__ENA = nRST & (count != '0);
  assign pipe_enq_v    = mem[rd_ptr];
  assign pop           = pipe_enq__ENA & pipe_enq__RDY;
  assign meth__RDY     = {NCH{nRST}} & (~hold_valid | grant);
  assign accept        = meth__ENA & meth__RDY;

  // Stage: combinational round-robin grant from registered state
  always_comb begin
    int unsigned j;
    grant     = '0;
    grant_idx = '0;
    push      = 1'b0;
    j         = 0;
    if (!full) begin
      for (int k = 0; k < NCH; k++) begin
        j = (int'(rr_ptr) + k) % NCH;
        if (!push && hold_valid[j]) begin
          push      = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = IDX_W'(j);
        end
      end
    end
    rr_next   = (int'(grant_idx) == NCH - 1) ? '0 : grant_idx + IDX_W'(1);
    push_word = {TAG_W'(grant_idx) + TAG_W'(1), hold_data[grant_idx]};
  end

  // Stage: control registers (hold flags, rr pointer, FIFO pointers, count)
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hold_valid <= '0;
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (accept[i]) begin
          hold_valid[i] <= 1'b1;
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
      if (push) begin
        rr_ptr <= rr_next;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Stage: datapath storage (payload capture, FIFO write), not reset
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCH; i++) begin
      if (accept[i]) begin
        hold_data[i] <= meth_v[i*DATA_W +: DATA_W];
      end
    end
    if (push) begin
      mem[wr_ptr] <= push_word;
    end
  end

endmodule
